pe_dot_sequencer: RTL and testbench

//  Upstream control stage for processing_element. Accepts a dot-product command, preloads up to
//  MEM_DEPTH weights into the PE local memory, then streams activations against the stored weights.
//  It closes each job with end_operation and pulses done when the PE result output holds the new sum.
//  It sits between the activation/weight buffers (valid/ready streams) and one processing_element.

---
 rtl/pe_pkg.sv | 15 +
 rtl/pe_dot_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pe_dot_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the processing element and its dot-product sequencer.
package pe_pkg;

    localparam int PE_INPUT_WIDTH = 16;
    localparam int PE_MEM_DEPTH   = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        FIN   = 3'd4
    } pe_seq_state_e;

endpackage

// File: rtl/pe_dot_sequencer.sv
// Dot-product job sequencer: preloads weights into a processing_element, streams activations
// against them, then closes the job with end_operation and a done pulse.
//
//   state | meaning
//   IDLE  | waiting for a command; bad lengths are rejected here with err_len
//   LOAD  | writing len weights into PE memory
//   RUN   | streaming len activations against stored weights
//   FLUSH | last product has landed; raise end_operation
//   FIN   | PE result register now holds the sum; raise done
module pe_dot_sequencer
    import pe_pkg::*;
#(
    parameter int INPUT_WIDTH = PE_INPUT_WIDTH,
    parameter int MEM_DEPTH   = PE_MEM_DEPTH,
    parameter int ADDR_WIDTH  = $clog2(MEM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [ADDR_WIDTH:0]    cmd_len_i,
    input  logic                   cmd_reuse_i,
    input  logic                   wgt_valid_i,
    output logic                   wgt_ready_o,
    input  logic [INPUT_WIDTH-1:0] wgt_data_i,
    input  logic                   act_valid_i,
    output logic                   act_ready_o,
    input  logic [INPUT_WIDTH-1:0] act_data_i,
    output logic [INPUT_WIDTH-1:0] pe_input_data_o,
    output logic [INPUT_WIDTH-1:0] pe_weight_o,
    output logic                   pe_write_weight_o,
    output logic                   pe_use_stored_weight_o,
    output logic [ADDR_WIDTH-1:0]  pe_mem_addr_o,
    output logic                   pe_end_operation_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_len_o
);

    localparam int LEN_W = ADDR_WIDTH + 1;

    pe_seq_state_e          state_q, state_d;
    logic [LEN_W-1:0]       idx_q, idx_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       loaded_len_q, loaded_len_d;
    logic [INPUT_WIDTH-1:0] input_data_q, input_data_d;
    logic [INPUT_WIDTH-1:0] weight_q, weight_d;
    logic                   write_weight_q, write_weight_d;
    logic                   use_stored_q, use_stored_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic                   end_op_q, end_op_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_len_q, err_len_d;
    logic                   len_bad;
    logic                   idx_last;

    assign len_bad = (cmd_len_i == '0) || (cmd_len_i > LEN_W'(MEM_DEPTH)) ||
                     (cmd_reuse_i && (cmd_len_i > loaded_len_q));
    assign idx_last = (idx_q == len_q - LEN_W'(1));

    assign cmd_ready_o = !rst && (state_q == IDLE);
    assign wgt_ready_o = (state_q == LOAD);
    assign act_ready_o = (state_q == RUN);

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        len_d          = len_q;
        loaded_len_d   = loaded_len_q;
        input_data_d   = '0;
        weight_d       = '0;
        write_weight_d = 1'b0;
        // Stored-weight reads are disabled only while a weight write may be in flight.
        use_stored_d   = (state_q != LOAD);
        mem_addr_d     = mem_addr_q;
        end_op_d       = 1'b0;
        done_d         = 1'b0;
        err_len_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (len_bad) begin
                        err_len_d = 1'b1;
                    end else begin
                        len_d = cmd_len_i;
                        idx_d = '0;
                        if (cmd_reuse_i) begin
                            state_d = RUN;
                        end else begin
                            state_d      = LOAD;
                            loaded_len_d = '0;
                        end
                    end
                end
            end
            LOAD: begin
                if (wgt_valid_i) begin
                    write_weight_d = 1'b1;
                    weight_d       = wgt_data_i;
                    mem_addr_d     = idx_q[ADDR_WIDTH-1:0];
                    if (idx_last) begin
                        loaded_len_d = len_q;
                        idx_d        = '0;
                        state_d      = RUN;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            RUN: begin
                if (act_valid_i) begin
                    input_data_d = act_data_i;
                    mem_addr_d   = idx_q[ADDR_WIDTH-1:0];
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = FLUSH;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            FLUSH: begin
                end_op_d = 1'b1;
                state_d  = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            len_q          <= '0;
            loaded_len_q   <= '0;
            input_data_q   <= '0;
            weight_q       <= '0;
            write_weight_q <= 1'b0;
            use_stored_q   <= 1'b0;
            mem_addr_q     <= '0;
            end_op_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_len_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            len_q          <= len_d;
            loaded_len_q   <= loaded_len_d;
            input_data_q   <= input_data_d;
            weight_q       <= weight_d;
            write_weight_q <= write_weight_d;
            use_stored_q   <= use_stored_d;
            mem_addr_q     <= mem_addr_d;
            end_op_q       <= end_op_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_len_q      <= err_len_d;
        end
    end

    assign pe_input_data_o        = input_data_q;
    assign pe_weight_o            = weight_q;
    assign pe_write_weight_o      = write_weight_q;
    assign pe_use_stored_weight_o = use_stored_q;
    assign pe_mem_addr_o          = mem_addr_q;
    assign pe_end_operation_o     = end_op_q;
    assign busy_o                 = busy_q;
    assign done_o                 = done_q;
    assign err_len_o              = err_len_q;

endmodule

// File: tb/tb_pe_dot_sequencer.sv
// Directed bench for pe_dot_sequencer driving a behavioural processing_element (32-bit result).
module tb_pe_dot_sequencer;

    localparam int IW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_reuse = 1'b0;
    logic [AW:0]   cmd_len = '0;
    logic          wgt_valid = 1'b0, act_valid = 1'b0;
    logic [IW-1:0] wgt_data = '0, act_data = '0;
    logic          cmd_ready, wgt_ready, act_ready;
    logic [IW-1:0] pe_input_data, pe_weight;
    logic          pe_write_weight, pe_use_stored_weight, pe_end_operation;
    logic [AW-1:0] pe_mem_addr;
    logic          busy, done, err_len;

    pe_dot_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_len_i(cmd_len), .cmd_reuse_i(cmd_reuse),
        .wgt_valid_i(wgt_valid), .wgt_ready_o(wgt_ready), .wgt_data_i(wgt_data),
        .act_valid_i(act_valid), .act_ready_o(act_ready), .act_data_i(act_data),
        .pe_input_data_o(pe_input_data), .pe_weight_o(pe_weight),
        .pe_write_weight_o(pe_write_weight), .pe_use_stored_weight_o(pe_use_stored_weight),
        .pe_mem_addr_o(pe_mem_addr), .pe_end_operation_o(pe_end_operation),
        .busy_o(busy), .done_o(done), .err_len_o(err_len)
    );

    always #5 clk = ~clk;

    // Behavioural PE: accumulates every cycle, latches the sum on end_operation.
    logic signed [IW-1:0] pe_mem [8];
    logic signed [IW-1:0] wsel;
    logic signed [31:0]   prod;
    logic [31:0]          acc, pe_result;
    assign wsel = pe_use_stored_weight ? pe_mem[pe_mem_addr] : $signed(pe_weight);
    assign prod = $signed(pe_input_data) * wsel;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            pe_result <= '0;
        end else begin
            if (pe_write_weight) pe_mem[pe_mem_addr] <= pe_weight;
            if (pe_end_operation) begin
                pe_result <= acc + prod;
                acc       <= '0;
            end else begin
                acc <= acc + prod;
            end
        end
    end

    // Handshake history and strobe monitors.
    logic act_hs_q, wgt_hs_q;
    int   cyc = 0;
    int   done_cnt = 0, err_cnt = 0, eo_cnt = 0, busy_cnt = 0, wr_cnt = 0, rd_cnt = 0;
    int   bad_in = 0, bad_w = 0;
    int   wr_log [64];
    int   rd_log [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            act_hs_q <= 1'b0;
            wgt_hs_q <= 1'b0;
        end else begin
            act_hs_q <= act_valid && act_ready;
            wgt_hs_q <= wgt_valid && wgt_ready;
        end
    end

    always @(negedge clk) begin
        if (!act_hs_q && pe_input_data != '0) bad_in++;
        if (!wgt_hs_q && (pe_write_weight || pe_weight != '0)) bad_w++;
        if (pe_write_weight) begin
            if (wr_cnt < 64) wr_log[wr_cnt] = int'(pe_mem_addr);
            wr_cnt++;
        end
        if (act_hs_q) begin
            if (rd_cnt < 64) rd_log[rd_cnt] = int'(pe_mem_addr);
            rd_cnt++;
        end
        if (done) done_cnt++;
        if (err_len) err_cnt++;
        if (pe_end_operation) eo_cnt++;
        if (busy) busy_cnt++;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int c0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input int len, input bit reuse);
        int g;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = (AW+1)'(len);
        cmd_reuse = reuse;
        g = 0;
        while (!cmd_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        c0        = cyc;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_reuse = 1'b0;
    endtask

    task automatic push(input bit is_act, input int n, input logic [IW-1:0] d [8], input bit rnd);
        int g;
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                g = 0;
                while ($urandom_range(0, 1) == 1 && g < 3) begin
                    if (is_act) act_valid = 1'b0; else wgt_valid = 1'b0;
                    @(negedge clk);
                    g++;
                end
            end
            if (is_act) begin act_valid = 1'b1; act_data = d[i]; end
            else        begin wgt_valid = 1'b1; wgt_data = d[i]; end
            g = 0;
            while (!(is_act ? act_ready : wgt_ready) && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (g >= 50) chk(is_act ? "act_ready_timeout" : "wgt_ready_timeout", 64'd0, 64'd1);
            @(negedge clk);
        end
        act_valid = 1'b0; act_data = '0;
        wgt_valid = 1'b0; wgt_data = '0;
    endtask

    task automatic wait_done(output int lat);
        int g;
        g = 0;
        while (!done && g < 60) begin
            @(negedge clk);
            g++;
        end
        if (g >= 60) chk("done_timeout", 64'(done), 64'd1);
        lat = cyc - c0 + 1;
    endtask

    logic [IW-1:0] w [8];
    logic [IW-1:0] a [8];
    int lat, d0, e0, eo0, b0, wr0, rd0;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_outputs", {pe_input_data, pe_weight, 3'(pe_mem_addr), pe_write_weight,
            pe_use_stored_weight, pe_end_operation, busy, done, err_len}, 64'd0);
        chk("rst_readies", {cmd_ready, wgt_ready, act_ready}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {cmd_ready, wgt_ready, act_ready, pe_use_stored_weight}, 64'b1001);

        // Job 1: load 1..4, stream 5..8 back-to-back.
        w = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
        a = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd0, 16'd0, 16'd0, 16'd0};
        d0 = done_cnt;
        do_cmd(4, 0);
        chk("load_ready", {busy, wgt_ready, act_ready, cmd_ready}, 64'b1100);
        push(1'b0, 4, w, 1'b0);
        push(1'b1, 4, a, 1'b0);
        wait_done(lat);
        chk("t1_result", pe_result, 64'd70);
        chk("t1_latency", lat, 64'd11);
        repeat (3) @(negedge clk);
        chk("t1_done_once", done_cnt - d0, 64'd1);
        chk("t1_idle", busy, 64'd0);

        // Job 2: reuse stored weights with all activations -1.
        a = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0};
        wr0 = wr_cnt;
        do_cmd(4, 1);
        push(1'b1, 4, a, 1'b0);
        wait_done(lat);
        chk("t2_result", pe_result, 64'h0000_0000_FFFF_FFF6);
        chk("t2_latency", lat, 64'd7);
        chk("t2_no_write", wr_cnt - wr0, 64'd0);

        // Rejected commands: len 0, len 9, reuse beyond loaded length 4.
        repeat (2) @(negedge clk);
        e0 = err_cnt; eo0 = eo_cnt; b0 = busy_cnt; wr0 = wr_cnt; d0 = done_cnt;
        do_cmd(0, 0);
        chk("t4_err_len0", err_len, 64'd1);
        do_cmd(9, 0);
        chk("t4_err_len9", err_len, 64'd1);
        do_cmd(5, 1);
        chk("t4_err_reuse5", err_len, 64'd1);
        repeat (3) @(negedge clk);
        chk("t4_err_count", err_cnt - e0, 64'd3);
        chk("t4_no_strobes", (wr_cnt - wr0) + (eo_cnt - eo0) + (done_cnt - d0), 64'd0);
        chk("t4_busy_low", busy_cnt - b0, 64'd0);

        // Job 3: randomly gapped streams; only accepted terms may contribute.
        w = '{16'hFFFE, 16'd4, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        a = '{16'd3, 16'hFFFB, 16'd32767, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        do_cmd(3, 0);
        push(1'b0, 3, w, 1'b1);
        push(1'b1, 3, a, 1'b1);
        wait_done(lat);
        chk("t3_result", pe_result, 64'd32741);

        // Job 4: full depth with extreme values; result wraps to 0.
        for (int i = 0; i < 8; i++) begin
            w[i] = 16'h8000;
            a[i] = 16'h8000;
        end
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_cmd(8, 0);
        push(1'b0, 8, w, 1'b0);
        push(1'b1, 8, a, 1'b0);
        wait_done(lat);
        chk("t5_result", pe_result, 64'd0);
        chk("t5_latency", lat, 64'd19);
        chk("t5_counts", {32'(wr_cnt - wr0), 32'(rd_cnt - rd0)}, {32'd8, 32'd8});
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t5_wr_addr%0d", i), wr_log[wr0 + i], i);
            chk($sformatf("t5_rd_addr%0d", i), rd_log[rd0 + i], i);
        end

        // Reset in the middle of RUN.
        w = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
        do_cmd(4, 0);
        push(1'b0, 4, w, 1'b0);
        act_valid = 1'b1; act_data = 16'd5;
        @(negedge clk);
        act_data = 16'd6;
        @(negedge clk);
        chk("t6_mid_run", {pe_input_data, busy, act_ready}, {16'd6, 2'b11});
        d0 = done_cnt; eo0 = eo_cnt;
        rst = 1'b1;
        #1;
        chk("t6_rst_outputs", {pe_input_data, pe_weight, 3'(pe_mem_addr), pe_write_weight,
            pe_use_stored_weight, pe_end_operation, busy, done, err_len}, 64'd0);
        chk("t6_rst_readies", {cmd_ready, wgt_ready, act_ready}, 64'd0);
        act_valid = 1'b0; act_data = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        do_cmd(1, 1);
        chk("t6_err_after_rst", err_len, 64'd1);
        repeat (8) @(negedge clk);
        chk("t6_no_done", (done_cnt - d0) + (eo_cnt - eo0), 64'd0);
        chk("idle_inputs_zero", bad_in, 64'd0);
        chk("weight_strobe_only_on_hs", bad_w, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
